// File: rtl/sdf_delay_stage_if.sv
// Sample-stream bundle for the SDF radix-2 delay/butterfly stage.
//
// Handshake: in_valid qualifies a for the current cycle and has no ready
// (the stage always accepts). out_valid qualifies y, y_tag and ovf for
// exactly one cycle per produced result. y and y_tag keep their last
// value while out_valid is low.
interface sdf_delay_stage_if #(
  parameter int N = 8
);
  logic                in_valid;
  logic signed [N-1:0] a;
  logic                out_valid;
  logic signed [N-1:0] y;
  logic                y_tag;
  logic                ovf;

  // Sample source / result sink side
  modport master (
    output in_valid, a,
    input  out_valid, y, y_tag, ovf
  );

  // Butterfly stage side
  modport slave (
    input  in_valid, a,
    output out_valid, y, y_tag, ovf
  );
endinterface

// File: rtl/sdf_delay_stage.sv
// Single-path delay-feedback radix-2 butterfly stage.
// A block is 2*DEPTH samples. The first half of a block is stored in the
// delay line. The second half pairs with it to emit sums at once and to
// store the differences. Those differences drain while the next block fills.
module sdf_delay_stage #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int SCALE = 0
) (
  input  logic               clk,
  input  logic               clear,
  sdf_delay_stage_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Sequencing state and the delay line. Entries are one bit wider than a
  // sample so that an unsaturated difference survives storage.
  logic [CW-1:0]     r_cnt;
  logic              r_primed;
  logic signed [N:0] r_dly [DEPTH];

  // Registered outputs
  logic signed [N-1:0] r_y;
  logic                r_y_tag;
  logic                r_out_valid;
  logic                r_ovf;

  logic                w_phase;
  logic signed [N:0]   w_dout;
  logic signed [N:0]   w_a_ext;
  logic signed [N:0]   w_sum;
  logic signed [N:0]   w_diff;
  logic signed [N:0]   w_fmt_in;
  logic signed [N:0]   w_push;
  logic signed [N-1:0] w_fmt_y;
  logic                w_sat;

  // The counter wraps at 2*DEPTH by plain overflow because DEPTH is a power
  // of two. Its MSB separates the fill half from the compute half.
  assign w_phase = r_cnt[CW-1];
  assign w_dout  = r_dly[DEPTH-1];
  assign w_a_ext = {bus.a[N-1], bus.a};
  assign w_sum   = w_dout + w_a_ext;
  assign w_diff  = w_dout - w_a_ext;

  // Route the sum (compute half) or the drained difference (fill half) to the
  // formatter. Route the new sample or the fresh difference into the line.
  assign w_fmt_in = w_phase ? w_sum  : w_dout;
  assign w_push   = w_phase ? w_diff : w_a_ext;

  // Reduce an N+1-bit result to N bits: saturate, or halve with floor
  always_comb begin
    w_sat   = 1'b0;
    w_fmt_y = w_fmt_in[N-1:0];
    if (SCALE != 0) begin
      w_fmt_y = w_fmt_in[N:1];
    end else if (w_fmt_in[N] != w_fmt_in[N-1]) begin
      w_sat   = 1'b1;
      w_fmt_y = w_fmt_in[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  // Advance counter, delay line and outputs on every valid sample
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_cnt       <= '0;
      r_primed    <= 1'b0;
      r_y         <= '0;
      r_y_tag     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      if (bus.in_valid) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == {CW{1'b1}}) begin
          r_primed <= 1'b1;
        end
        r_dly[0] <= w_push;
        for (int i = 1; i < DEPTH; i++) begin
          r_dly[i] <= r_dly[i-1];
        end
        if (w_phase) begin
          r_y         <= w_fmt_y;
          r_y_tag     <= 1'b0;
          r_out_valid <= 1'b1;
          r_ovf       <= w_sat;
        end else if (r_primed) begin
          r_y         <= w_fmt_y;
          r_y_tag     <= 1'b1;
          r_out_valid <= 1'b1;
          r_ovf       <= w_sat;
        end
      end
    end
  end

  assign bus.y         = r_y;
  assign bus.y_tag     = r_y_tag;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sdf_delay_stage.sv
// Bench for sdf_delay_stage. Three instances share one stimulus stream:
// u0 (DEPTH=4, saturate), u1 (DEPTH=4, halve), u2 (DEPTH=1, saturate).
// A block-level model predicts every output cycle. Literal lists pin the
// key sequences of u0/u1.
module tb_sdf_delay_stage;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  sdf_delay_stage_if #(.N(8)) if0 ();
  sdf_delay_stage_if #(.N(8)) if1 ();
  sdf_delay_stage_if #(.N(8)) if2 ();

  sdf_delay_stage #(.N(8), .DEPTH(4), .SCALE(0)) u0 (.clk(clk), .clear(clear), .bus(if0));
  sdf_delay_stage #(.N(8), .DEPTH(4), .SCALE(1)) u1 (.clk(clk), .clear(clear), .bus(if1));
  sdf_delay_stage #(.N(8), .DEPTH(1), .SCALE(0)) u2 (.clk(clk), .clear(clear), .bus(if2));

  int errors = 0;
  int checks = 0;

  // ---------------- model ----------------
  int depth_of [3] = '{4, 4, 1};
  int scale_of [3] = '{0, 1, 0};
  int hist [3][0:1023];
  int hcnt [3];
  int exp_y [3];
  bit exp_v [3];
  bit exp_t [3];
  bit exp_o [3];

  // Captured valid outputs {ovf, tag, y} for literal comparison
  logic [9:0] cap0[$];
  logic [9:0] cap1[$];
  logic [9:0] exp_q[$];

  function automatic int fmt(input int v, input int sc, output bit ov);
    ov = 1'b0;
    if (sc != 0) return v >>> 1;
    if (v > 127) begin ov = 1'b1; return 127; end
    if (v < -128) begin ov = 1'b1; return -128; end
    return v;
  endfunction

  function automatic logic [9:0] mk(input bit o, input bit t, input int y);
    return {o, t, y[7:0]};
  endfunction

  // Model one cycle: sample number within the block decides the output
  task automatic model_step(input int k, input bit v, input int a);
    int d, idx, pos, blk, r;
    bit ov;
    exp_v[k] = 1'b0;
    exp_o[k] = 1'b0;
    if (!v) return;
    d   = depth_of[k];
    idx = hcnt[k];
    hist[k][idx] = a;
    hcnt[k] = hcnt[k] + 1;
    pos = idx % (2 * d);
    blk = idx / (2 * d);
    if (pos >= d) begin
      r = fmt(hist[k][idx-d] + a, scale_of[k], ov);
      exp_v[k] = 1'b1; exp_y[k] = r; exp_t[k] = 1'b0; exp_o[k] = ov;
    end else if (blk > 0) begin
      r = fmt(hist[k][idx-2*d] - hist[k][idx-d], scale_of[k], ov);
      exp_v[k] = 1'b1; exp_y[k] = r; exp_t[k] = 1'b1; exp_o[k] = ov;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hcnt[k] = 0; exp_y[k] = 0; exp_v[k] = 0; exp_t[k] = 0; exp_o[k] = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_inst(input int k, input bit v, input int y, input bit t, input bit o);
    checks++;
    if (v !== exp_v[k] || o !== exp_o[k] || y != exp_y[k] || t !== exp_t[k]) begin
      errors++;
      $display("FAIL cyc u%0d: got v=%0b y=%0d tag=%0b ovf=%0b want v=%0b y=%0d tag=%0b ovf=%0b",
               k, v, y, t, o, exp_v[k], exp_y[k], exp_t[k], exp_o[k]);
    end
    if (v && k == 0) cap0.push_back(mk(o, t, y));
    if (v && k == 1) cap1.push_back(mk(o, t, y));
  endtask

  task automatic check_all();
    check_inst(0, if0.out_valid, int'(if0.y), if0.y_tag, if0.ovf);
    check_inst(1, if1.out_valid, int'(if1.y), if1.y_tag, if1.ovf);
    check_inst(2, if2.out_valid, int'(if2.y), if2.y_tag, if2.ovf);
  endtask

  task automatic check_cap(input string name, input int sel);
    logic [9:0] got[$];
    int n;
    if (sel == 0) got = cap0; else got = cap1;
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s len: got %0d want %0d", name, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s[%0d]: got ovf/tag/y=%h want %h", name, i, got[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int a);
    if0.in_valid = v; if0.a = 8'(a);
    if1.in_valid = v; if1.a = 8'(a);
    if2.in_valid = v; if2.a = 8'(a);
    for (int k = 0; k < 3; k++) model_step(k, v, a);
  endtask

  task automatic step(input bit v, input int a);
    @(negedge clk);
    check_all();
    drive(v, a);
  endtask

  // Clear asserted between clock edges; outputs must drop immediately
  task automatic do_clear();
    @(negedge clk);
    check_all();
    drive(1'b0, 0);
    #2 clear = 1'b1;
    #1;
    checks++;
    if (if0.y !== 8'sd0 || if0.out_valid !== 1'b0 || if0.ovf !== 1'b0 ||
        if1.y !== 8'sd0 || if1.out_valid !== 1'b0 ||
        if2.y !== 8'sd0 || if2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got y0=%0d v0=%0b o0=%0b y1=%0d v1=%0b y2=%0d v2=%0b want all 0",
               if0.y, if0.out_valid, if0.ovf, if1.y, if1.out_valid, if2.y, if2.out_valid);
    end
    model_reset();
    @(posedge clk);
    #2 clear = 1'b0;
    cap0.delete();
    cap1.delete();
  endtask

  task automatic basic_literals();
    exp_q = '{mk(0,0,6), mk(0,0,8), mk(0,0,10), mk(0,0,12),
              mk(0,1,-4), mk(0,1,-4), mk(0,1,-4), mk(0,1,-4),
              mk(0,0,22), mk(0,0,24), mk(0,0,26), mk(0,0,28)};
  endtask

  // ---------------- directed tests ----------------
  initial begin
    model_reset();
    drive(1'b0, 0);
    repeat (2) @(posedge clk);
    #2 clear = 1'b0;

    // Reset state, then basic stream 1..16
    step(0, 0);
    for (int i = 1; i <= 16; i++) step(1, i);
    step(0, 0);
    step(0, 0);
    basic_literals();
    check_cap("basic", 0);

    // Same stream with 3-cycle gaps after samples 2, 4 (phase edge), 6
    do_clear();
    for (int i = 1; i <= 16; i++) begin
      step(1, i);
      if (i == 2 || i == 4 || i == 6) repeat (3) step(0, 0);
    end
    step(0, 0);
    basic_literals();
    check_cap("stall", 0);

    // Saturation on u0; halving of the same stream on u1
    do_clear();
    for (int i = 0; i < 8; i++) step(1, 100);
    for (int i = 0; i < 4; i++) step(1, -100);
    for (int i = 0; i < 4; i++) step(1, 100);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(0, 0);
    exp_q = '{mk(1,0,127), mk(1,0,127), mk(1,0,127), mk(1,0,127),
              mk(0,1,0), mk(0,1,0), mk(0,1,0), mk(0,1,0),
              mk(0,0,0), mk(0,0,0), mk(0,0,0), mk(0,0,0),
              mk(1,1,-128), mk(1,1,-128), mk(1,1,-128), mk(1,1,-128)};
    check_cap("sat", 0);
    exp_q = '{mk(0,0,100), mk(0,0,100), mk(0,0,100), mk(0,0,100),
              mk(0,1,0), mk(0,1,0), mk(0,1,0), mk(0,1,0),
              mk(0,0,0), mk(0,0,0), mk(0,0,0), mk(0,0,0),
              mk(0,1,-100), mk(0,1,-100), mk(0,1,-100), mk(0,1,-100)};
    check_cap("halve_big", 1);

    // Halving with small values: floor(k/2)
    do_clear();
    for (int i = 0; i < 8; i++) step(1, 100);
    for (int i = 1; i <= 4; i++) step(1, i);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(0, 0);
    exp_q = '{mk(0,0,100), mk(0,0,100), mk(0,0,100), mk(0,0,100),
              mk(0,1,0), mk(0,1,0), mk(0,1,0), mk(0,1,0),
              mk(0,0,0), mk(0,0,1), mk(0,0,1), mk(0,0,2)};
    check_cap("halve_small", 1);

    // Mid-block clear discards the partial block
    do_clear();
    for (int i = 1; i <= 6; i++) step(1, i);
    do_clear();
    for (int i = 1; i <= 16; i++) step(1, i);
    step(0, 0);
    basic_literals();
    check_cap("mid_clear", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
